// File: rtl/program_loader_pkg.sv
// Shared SAP-1 definitions: memory geometry defaults, opcode constants
// and the program loader state encoding.
package program_loader_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_FINISH,
        S_RUN
    } load_state_t;

endpackage

// File: rtl/program_loader_load_counter.sv
// load_counter: RAM write address and words-written counter.
// Ports: clk, low_clr, clr, step_count, step_addr -> addr, count, at_end.
module load_counter #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              low_clr,
    input  logic              clr,
    input  logic              step_count,
    input  logic              step_addr,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W:0]   count,
    output logic              at_end
);

    // The address never wraps: the top address ends the load instead
    // of stepping, so count can reach 2^ADDR_W in its extra bit.
    assign at_end = &addr;

    always_ff @(posedge clk or negedge low_clr) begin
        if (!low_clr) begin
            addr  <= '0;
            count <= '0;
        end else if (clr) begin
            addr  <= '0;
            count <= '0;
        end else begin
            if (step_count)
                count <= count + 1'b1;
            if (step_addr)
                addr <= addr + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: streams host words into SAP-1 RAM, holding the CPU in
// clear while loading. Ports: clk, low_clr, start, data_in/valid/last,
// data_ready, ram_addr, ram_data, low_ram_we, cpu_clr, done, word_count.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              low_clr,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              data_last,
    output logic              data_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              low_ram_we,
    output logic              cpu_clr,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    load_state_t       state;
    load_state_t       state_nx;
    logic [DATA_W-1:0] word_q;
    logic              last_q;
    logic              capture;
    logic              clr;
    logic              step_count;
    logic              step_addr;
    logic              at_end;

    load_counter #(
        .ADDR_W(ADDR_W)
    ) u_cnt (
        .clk       (clk),
        .low_clr   (low_clr),
        .clr       (clr),
        .step_count(step_count),
        .step_addr (step_addr),
        .addr      (ram_addr),
        .count     (word_count),
        .at_end    (at_end)
    );

    always_ff @(posedge clk or negedge low_clr) begin
        if (!low_clr)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge low_clr) begin
        if (!low_clr) begin
            word_q <= '0;
            last_q <= 1'b0;
        end else if (capture) begin
            word_q <= data_in;
            last_q <= data_last;
        end
    end

    always_comb begin
        state_nx   = state;
        capture    = 1'b0;
        clr        = 1'b0;
        step_count = 1'b0;
        step_addr  = 1'b0;
        unique case (state)
            S_IDLE, S_RUN: begin
                if (start) begin
                    clr      = 1'b1;
                    state_nx = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (data_valid) begin
                    capture  = 1'b1;
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                step_count = 1'b1;
                if (last_q || at_end) begin
                    state_nx = S_FINISH;
                end else begin
                    step_addr = 1'b1;
                    state_nx  = S_ACCEPT;
                end
            end
            S_FINISH: state_nx = S_RUN;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Strobes decode straight from the state register, so reset
    // releases the write strobe without waiting for a clock.
    assign ram_data   = word_q;
    assign data_ready = (state == S_ACCEPT);
    assign low_ram_we = (state != S_WRITE);
    assign cpu_clr    = (state != S_RUN);
    assign done       = (state == S_FINISH);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected RAM
// writes and done counts, a negedge monitor pops and compares them.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       low_clr;
    logic       start;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_last;
    logic       data_ready;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       low_ram_we;
    logic       cpu_clr;
    logic       done;
    logic [4:0] word_count;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wq[$];
    logic [4:0] dq[$];
    int         checks = 0;
    int         errors = 0;

    program_loader dut (
        .clk       (clk),
        .low_clr   (low_clr),
        .start     (start),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_last (data_last),
        .data_ready(data_ready),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .low_ram_we(low_ram_we),
        .cpu_clr   (cpu_clr),
        .done      (done),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every write strobe and done pulse must match the queues.
    wr_t        e;
    logic [4:0] ew;
    always @(negedge clk) begin
        if (low_clr === 1'b1) begin
            if (low_ram_we === 1'b0) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0h data=%0h",
                             ram_addr, ram_data);
                end else begin
                    e = wq.pop_front();
                    if (ram_addr !== e.a || ram_data !== e.d) begin
                        errors++;
                        $display("FAIL write got=%0h:%0h want=%0h:%0h",
                                 ram_addr, ram_data, e.a, e.d);
                    end
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done count=%0d", word_count);
                end else begin
                    ew = dq.pop_front();
                    if (word_count !== ew || cpu_clr !== 1'b1) begin
                        errors++;
                        $display("FAIL done_count got=%0d/%0b want=%0d/1",
                                 word_count, cpu_clr, ew);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l,
                        input logic [3:0] a);
        int n;
        wq.push_back('{a: a, d: d});
        data_in    = d;
        data_last  = l;
        data_valid = 1'b1;
        n = 0;
        while (data_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (data_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=%0b want=1", data_ready);
        end else begin
            tick();
        end
        data_valid = 1'b0;
        data_last  = 1'b0;
    endtask

    task automatic wait_done(input logic [4:0] cnt);
        int n;
        dq.push_back(cnt);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got=%0b want=1", done);
        end
    endtask

    logic [7:0] tw[4];

    initial begin
        int idx;
        int cyc;
        logic acc;
        low_clr    = 1'b0;
        start      = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        data_last  = 1'b0;
        tw[0] = 8'h3C;
        tw[1] = 8'hC3;
        tw[2] = 8'h5A;
        tw[3] = 8'hA5;

        // Reset state
        #12;
        chk("rst_cpu_clr", cpu_clr, 1);
        chk("rst_ready", data_ready, 0);
        chk("rst_we", low_ram_we, 1);
        chk("rst_done", done, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_data", ram_data, 0);
        chk("rst_count", word_count, 0);
        @(negedge clk);
        low_clr = 1'b1;
        tick();
        chk("idle_ready", data_ready, 0);

        // Three-word load, last on the third
        do_start();
        chk("t1_clr", cpu_clr, 1);
        chk("t1_ready", data_ready, 1);
        send(8'h0E, 1'b0, 4'd0);
        send(8'h1F, 1'b0, 4'd1);
        send(8'hF0, 1'b1, 4'd2);
        wait_done(5'd3);
        tick();
        chk("t1_clr_low", cpu_clr, 0);
        chk("t1_done_low", done, 0);
        chk("t1_count", word_count, 3);

        // Reload from RUN
        do_start();
        chk("t2_clr", cpu_clr, 1);
        chk("t2_count0", word_count, 0);
        send(8'hAA, 1'b0, 4'd0);
        send(8'h55, 1'b1, 4'd1);
        wait_done(5'd2);
        tick();
        chk("t2_count", word_count, 2);

        // Sixteen words, last never set
        do_start();
        for (int i = 0; i < 16; i++)
            send(8'(i), 1'b0, 4'(i));
        wait_done(5'd16);
        tick();
        chk("t3_count", word_count, 16);
        data_valid = 1'b1;
        repeat (4) tick();
        chk("t3_run_ready", data_ready, 0);
        data_valid = 1'b0;

        // data_valid toggling every cycle
        do_start();
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 60) begin
            data_valid = cyc[0];
            data_in    = tw[idx];
            data_last  = (idx == 3);
            acc = data_valid && data_ready;
            if (acc)
                wq.push_back('{a: 4'(idx), d: tw[idx]});
            tick();
            if (acc)
                idx++;
            cyc++;
        end
        data_valid = 1'b0;
        data_last  = 1'b0;
        chk("t4_words", idx, 4);
        wait_done(5'd4);
        tick();
        chk("t4_count", word_count, 4);

        // start pulsed during WRITE and ACCEPT
        do_start();
        send(8'h11, 1'b0, 4'd0);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        chk("t5_count1", word_count, 1);
        chk("t5_addr1", ram_addr, 1);
        send(8'h22, 1'b0, 4'd1);
        send(8'h33, 1'b1, 4'd2);
        wait_done(5'd3);
        tick();
        chk("t5_count", word_count, 3);

        // Reset in the WRITE cycle of word 5
        do_start();
        for (int i = 0; i < 5; i++)
            send(8'h40 + 8'(i), 1'b0, 4'(i));
        chk("t6_in_write", low_ram_we, 0);
        @(negedge clk);
        #1;
        low_clr = 1'b0;
        #1;
        chk("t6_we", low_ram_we, 1);
        chk("t6_clr", cpu_clr, 1);
        chk("t6_count", word_count, 0);
        chk("t6_ready", data_ready, 0);
        chk("t6_addr", ram_addr, 0);
        @(negedge clk);
        low_clr    = 1'b1;
        data_valid = 1'b1;
        repeat (3) tick();
        chk("t6_idle_ready", data_ready, 0);
        chk("t6_idle_clr", cpu_clr, 1);
        data_valid = 1'b0;
        do_start();
        send(8'h77, 1'b1, 4'd0);
        wait_done(5'd1);
        tick();
        chk("t6_count_new", word_count, 1);

        repeat (3) tick();
        chk("wq_empty", wq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, RAM address width (16-word SAP-1 memory).
REQ-002 SHALL have parameter DATA_W, default 8, RAM word width.
REQ-003 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-004 SHALL have port low_clr  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request to (re)load the program, sampled in IDLE and RUN.
REQ-006 SHALL have port data_in  input  DATA_W  program word from host.
REQ-007 SHALL have port data_valid  input  1  data_in holds a valid word.
REQ-008 SHALL have port data_last  input  1  qualifies data_in as the final word; meaningful only with data_valid.
REQ-009 SHALL have port data_ready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port ram_addr  output  ADDR_W  RAM write address.
REQ-011 SHALL have port ram_data  output  DATA_W  RAM write data.
REQ-012 SHALL have port low_ram_we  output  1  active-low RAM write strobe.
REQ-013 SHALL have port cpu_clr  output  1  active-high clear to the CPU ring counter and program counter.
REQ-014 SHALL have port done  output  1  one-cycle pulse when loading completes.
REQ-015 SHALL have port word_count  output  ADDR_W+1  number of words written in the current or last load.

Function
REQ-016 SHALL implement states IDLE, ACCEPT, WRITE, FINISH, RUN.
REQ-017 IDLE: cpu_clr=1, data_ready=0; start=1 -> ACCEPT, address counter and word_count cleared to 0.
REQ-018 ACCEPT: data_ready=1; data_valid=1 -> capture data_in and data_last into registers, go to WRITE; otherwise stay.
REQ-019 WRITE: exactly one cycle, low_ram_we=0, ram_addr=address counter, ram_data=captured word, data_ready=0; word_count increments by 1 at end of cycle.
REQ-020 After WRITE: captured last=1 or address counter=2^ADDR_W-1 -> FINISH; otherwise address counter increments by 1 -> ACCEPT.
REQ-021 FINISH: one cycle, done=1, cpu_clr=1, then RUN.
REQ-022 RUN: cpu_clr=0, data_ready=0, low_ram_we=1; start=1 -> ACCEPT with address counter and word_count cleared, cpu_clr=1 from the next cycle.
REQ-023 Throughput SHALL be one word per two cycles when data_valid is held high; word k written to address k.
REQ-024 ram_addr and ram_data SHALL be registered and stable for the whole WRITE cycle; low_ram_we SHALL be high in all states except WRITE.
REQ-025 Addresses not reached in a load SHALL NOT be written; loader does not clear unused RAM.
REQ-026 start in ACCEPT, WRITE or FINISH SHALL be ignored.
REQ-027 data_valid outside ACCEPT SHALL be ignored and no word consumed.
REQ-028 A 16th word SHALL end the load regardless of data_last; word_count=16 (no wrap of counter).
REQ-029 cpu_clr SHALL be high in every state except RUN, so the CPU never fetches during a load.

Reset
REQ-030 low_clr=0 SHALL asynchronously force IDLE, cpu_clr=1, data_ready=0, low_ram_we=1, done=0, ram_addr=0, ram_data=0, word_count=0.
REQ-031 Reset during WRITE SHALL deassert low_ram_we immediately; the partial load is abandoned and start is required again.
REQ-032 Release of low_clr SHALL take effect on the first clk edge with low_clr=1; no output change before that edge.

Structure
REQ-033 State encoding and ADDR_W/DATA_W defaults SHALL live in the shared SAP-1 package alongside the opcode constants.
REQ-034 Single flat module; the address/word counter is the only natural sub-block and MAY be a sub-module named load_counter.

Verification
REQ-035 Reset, start, 3 words 0x0E,0x1F,0xF0 with last on the third -> addresses 0,1,2 written in order, done pulse once, word_count=3, cpu_clr falls the cycle after done.
REQ-036 Start, 16 words 0x00..0x0F with last never set -> writes to addresses 0..15, load ends after address 15, word_count=16, no 17th write.
REQ-037 data_valid toggling 1/0 every cycle in ACCEPT -> each word written exactly once, no duplicates or drops.
REQ-038 In RUN, start=1 -> cpu_clr=1 next cycle, reload of 2 words writes addresses 0,1, word_count=2.
REQ-039 low_clr asserted mid-WRITE of word 5 -> low_ram_we high asynchronously, state IDLE, word_count=0, cpu_clr=1.
REQ-040 start pulsed during ACCEPT and WRITE -> no counter reset, load completes normally.
